// File: rtl/clk_enable_gen_pkg.sv
// Shared types and constants for the clock-enable generator.
package clk_enable_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FILTER = 2'd1,
        ST_RUN    = 2'd2,
        ST_RELOAD = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        if (v == {LOSS_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + LOSS_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// One enable channel: clamps N/P, counts down to the next strobe and registers it.
module clk_enable_chan
    import clk_enable_gen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             en,
    input  logic [DIV_W-1:0] n,
    input  logic [DIV_W-1:0] p,
    output logic             ce
);

    logic [DIV_W-1:0] n_eff_s;
    logic [DIV_W-1:0] p_eff_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nx_s;
    logic             ce_nx_s;

    // Effective ratio and phase: N of 0 acts as 1, P is clamped into [0, N_eff-1]
    always_comb begin
        n_eff_s = n;
        p_eff_s = p;
        if (n == {DIV_W{1'b0}}) begin
            n_eff_s = DIV_W'(1);
        end else begin
            n_eff_s = n;
        end
        if (p < n_eff_s) begin
            p_eff_s = p;
        end else begin
            p_eff_s = n_eff_s - DIV_W'(1);
        end
    end

    // cnt_r holds the number of cycles still to pass before the next strobe
    always_comb begin
        cnt_nx_s = cnt_r;
        ce_nx_s  = 1'b0;
        if (start) begin
            if (p_eff_s == {DIV_W{1'b0}}) begin
                ce_nx_s  = en;
                cnt_nx_s = n_eff_s - DIV_W'(1);
            end else begin
                ce_nx_s  = 1'b0;
                cnt_nx_s = p_eff_s - DIV_W'(1);
            end
        end else if (run) begin
            if (cnt_r == {DIV_W{1'b0}}) begin
                ce_nx_s  = en;
                cnt_nx_s = n_eff_s - DIV_W'(1);
            end else begin
                ce_nx_s  = 1'b0;
                cnt_nx_s = cnt_r - DIV_W'(1);
            end
        end else begin
            ce_nx_s  = 1'b0;
            cnt_nx_s = cnt_r;
        end
    end

    // Counter and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {DIV_W{1'b0}};
            ce    <= 1'b0;
        end else begin
            cnt_r <= cnt_nx_s;
            ce    <= ce_nx_s;
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Derives NUM_CH programmable clock-enable strobes from one PLL clock and
// qualifies the PLL lock flag (synchroniser, filter, loss-of-lock counter).
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int LOCK_SYNC   = 2,
    parameter int LOCK_FILTER = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH*DIV_W-1:0] phase_ofs,
    input  logic                    cfg_update,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    sync_pulse,
    output logic                    locked_stable,
    output logic                    cfg_ack,
    output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

    localparam int                        FILT_W    = $clog2(LOCK_FILTER + 1);
    localparam logic [FILT_W-1:0]         FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [NUM_CH*DIV_W-1:0]   DIV_RST   = {NUM_CH{DIV_W'(1)}};

    logic [LOCK_SYNC-1:0]    sync_r;
    logic                    lk_s;
    state_t                  state_r;
    state_t                  state_nx_s;
    logic [FILT_W-1:0]       filt_r;
    logic [FILT_W-1:0]       filt_nx_s;
    logic                    pending_r;
    logic                    pending_nx_s;
    logic                    loss_s;
    logic                    run_nx_s;
    logic                    start_s;
    logic                    ack_nx_s;
    logic [NUM_CH*DIV_W-1:0] div_r;
    logic [NUM_CH*DIV_W-1:0] phase_r;

    assign lk_s = sync_r[LOCK_SYNC-1];

    // Lock-flag synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {LOCK_SYNC{1'b0}};
        end else begin
            sync_r <= {sync_r[LOCK_SYNC-2:0], pll_locked};
        end
    end

    // Lock filter / run-control next state
    always_comb begin
        state_nx_s = state_r;
        filt_nx_s  = filt_r;
        loss_s     = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (lk_s) begin
                    filt_nx_s  = FILT_W'(1);
                    state_nx_s = (FILT_LAST == {FILT_W{1'b0}}) ? ST_RUN : ST_FILTER;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_FILTER: begin
                if (!lk_s) begin
                    state_nx_s = ST_WAIT;
                end else if (filt_r == FILT_LAST) begin
                    filt_nx_s  = filt_r + FILT_W'(1);
                    state_nx_s = ST_RUN;
                end else begin
                    filt_nx_s  = filt_r + FILT_W'(1);
                    state_nx_s = ST_FILTER;
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    loss_s     = 1'b1;
                    state_nx_s = ST_WAIT;
                end else if (cfg_update || pending_r) begin
                    state_nx_s = ST_RELOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_RELOAD: begin
                if (!lk_s) begin
                    loss_s     = 1'b1;
                    state_nx_s = ST_WAIT;
                end else if (cfg_update) begin
                    state_nx_s = ST_RELOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_WAIT;
            end
        endcase
    end

    // A config captured while not running is acknowledged at the next alignment point;
    // one captured on the very cycle RUN is entered stays pending and forces a RELOAD
    always_comb begin
        run_nx_s     = (state_nx_s == ST_RUN);
        start_s      = run_nx_s && (state_r != ST_RUN);
        pending_nx_s = pending_r;
        if (cfg_update && (state_r != ST_RUN) && (state_r != ST_RELOAD)) begin
            pending_nx_s = 1'b1;
        end else if (start_s) begin
            pending_nx_s = 1'b0;
        end else begin
            pending_nx_s = pending_r;
        end
        ack_nx_s = (state_nx_s == ST_RELOAD) ||
                   (start_s && pending_r && (state_r != ST_RELOAD));
    end

    // Control state, shadow config and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_WAIT;
            filt_r        <= {FILT_W{1'b0}};
            pending_r     <= 1'b0;
            div_r         <= DIV_RST;
            phase_r       <= {(NUM_CH*DIV_W){1'b0}};
            locked_stable <= 1'b0;
            sync_pulse    <= 1'b0;
            cfg_ack       <= 1'b0;
            lock_loss_cnt <= {LOSS_CNT_W{1'b0}};
        end else begin
            state_r       <= state_nx_s;
            filt_r        <= filt_nx_s;
            pending_r     <= pending_nx_s;
            if (cfg_update) begin
                div_r   <= div_ratio;
                phase_r <= phase_ofs;
            end
            locked_stable <= run_nx_s;
            sync_pulse    <= start_s;
            cfg_ack       <= ack_nx_s;
            if (loss_s) begin
                lock_loss_cnt <= sat_inc(lock_loss_cnt);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_enable_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (reset_n),
            .start (start_s),
            .run   (run_nx_s),
            .en    (ch_enable[g]),
            .n     (div_r[g*DIV_W +: DIV_W]),
            .p     (phase_r[g*DIV_W +: DIV_W]),
            .ce    (ce_out[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_clk_enable_gen;

    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam logic [4:0] M_ALL = 5'b11111;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pll_locked = 1'b0;
    logic              cfg_update = 1'b0;
    logic [NCH*DW-1:0] div_ratio = '0;
    logic [NCH*DW-1:0] phase_ofs = '0;
    logic [NCH-1:0]    ch_enable = '1;
    logic [NCH-1:0]    ce_out;
    logic              sync_pulse;
    logic              locked_stable;
    logic              cfg_ack;
    logic [7:0]        lock_loss_cnt;

    typedef struct {
        logic [2:0] ce;
        logic       sy;
        logic       lk;
        logic       ack;
        logic [7:0] cnt;
        logic [4:0] m;
        int         tag;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .LOCK_SYNC   (2),
        .LOCK_FILTER (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .div_ratio     (div_ratio),
        .phase_ofs     (phase_ofs),
        .cfg_update    (cfg_update),
        .ch_enable     (ch_enable),
        .ce_out        (ce_out),
        .sync_pulse    (sync_pulse),
        .locked_stable (locked_stable),
        .cfg_ack       (cfg_ack),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Monitor: compares every queued expectation against the DUT outputs of this cycle
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.m[0]) begin
                vectors++;
                if (ce_out !== e.ce) begin
                    miscompares++;
                    $display("FAIL t%0d.%0d ce_out got %b want %b", e.tag, e.idx, ce_out, e.ce);
                end
            end
            if (e.m[1]) begin
                vectors++;
                if (sync_pulse !== e.sy) begin
                    miscompares++;
                    $display("FAIL t%0d.%0d sync_pulse got %b want %b", e.tag, e.idx, sync_pulse, e.sy);
                end
            end
            if (e.m[2]) begin
                vectors++;
                if (locked_stable !== e.lk) begin
                    miscompares++;
                    $display("FAIL t%0d.%0d locked_stable got %b want %b", e.tag, e.idx, locked_stable, e.lk);
                end
            end
            if (e.m[3]) begin
                vectors++;
                if (cfg_ack !== e.ack) begin
                    miscompares++;
                    $display("FAIL t%0d.%0d cfg_ack got %b want %b", e.tag, e.idx, cfg_ack, e.ack);
                end
            end
            if (e.m[4]) begin
                vectors++;
                if (lock_loss_cnt !== e.cnt) begin
                    miscompares++;
                    $display("FAIL t%0d.%0d lock_loss_cnt got %0d want %0d", e.tag, e.idx, lock_loss_cnt, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] ce, input logic sy, input logic lk, input logic ack,
                            input logic [7:0] cnt, input logic [4:0] m, input int tag, input int idx);
        exp_t e;
        e.ce = ce; e.sy = sy; e.lk = lk; e.ack = ack; e.cnt = cnt; e.m = m;
        e.tag = tag; e.idx = idx;
        sb.push_back(e);
    endtask

    function automatic logic on_phase(input int k, input int p, input int n);
        return (k >= p) && (((k - p) % n) == 0);
    endfunction

    initial begin
        logic [2:0] c;
        logic       en_edge;
        int         want;

        // Reset state
        push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 0, 0);
        @(negedge clk);
        tick();
        reset_n = 1'b1;

        // Config written before lock: N={4,1,3} P={0,0,2} (ch0 in low byte)
        div_ratio  = {8'd3, 8'd1, 8'd4};
        phase_ofs  = {8'd2, 8'd0, 8'd0};
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 1, 0);

        // Filter glitch after 10 high cycles restarts the full count
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 2, i);
        end
        pll_locked = 1'b0;
        tick();
        push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 2, 11);
        pll_locked = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 2, 100 + i);
        end

        // Lock-up: T0 on the 18th cycle, pending config acknowledged there
        for (int k = 0; k < 12; k++) begin
            tick();
            c = {on_phase(k, 2, 3), 1'b1, on_phase(k, 0, 4)};
            push_exp(c, k == 0, 1'b1, k == 0, 8'd0, M_ALL, 3, k);
        end

        // Live reconfig: ch0 N=5 P=7 -> P clamps to 4
        div_ratio[7:0] = 8'd5;
        phase_ofs[7:0] = 8'd7;
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 1'b1, 8'd0, M_ALL, 4, 0);
        for (int k = 0; k < 14; k++) begin
            tick();
            c = {on_phase(k, 2, 3), 1'b1, on_phase(k, 4, 5)};
            push_exp(c, k == 0, 1'b1, 1'b0, 8'd0, M_ALL, 4, k + 1);
        end

        // Edge configs: ch1 N=0 P=3 acts as N=1; ch2 gated off for a while
        div_ratio[15:8] = 8'd0;
        phase_ofs[15:8] = 8'd3;
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 1'b1, 8'd0, M_ALL, 5, 0);
        for (int k = 0; k < 16; k++) begin
            en_edge = ch_enable[2];
            tick();
            c = {on_phase(k, 2, 3) && en_edge, 1'b1, on_phase(k, 4, 5)};
            push_exp(c, k == 0, 1'b1, 1'b0, 8'd0, M_ALL, 5, k + 1);
            ch_enable[2] = !((k >= 3) && (k < 9));
        end

        // Loss of lock: seen after the synchroniser delay
        pll_locked = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            push_exp(3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 5'b10100, 6, i);
        end
        tick();
        push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd1, M_ALL, 6, 3);

        // Repeated loss events saturate the counter at 255
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b1;
            for (int j = 0; j < 18; j++) tick();
            push_exp(3'b010, 1'b1, 1'b1, 1'b0, 8'd0, 5'b01111, 7, i);
            pll_locked = 1'b0;
            for (int j = 0; j < 3; j++) tick();
            want = (i > 255) ? 255 : i;
            push_exp(3'b000, 1'b0, 1'b0, 1'b0, want[7:0], M_ALL, 7, 1000 + i);
        end

        // Async reset mid-RUN clears outputs without a clock edge
        pll_locked = 1'b1;
        for (int j = 0; j < 18; j++) tick();
        push_exp(3'b010, 1'b1, 1'b1, 1'b0, 8'd255, M_ALL, 8, 0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 8, 1);
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick();
            push_exp(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL, 8, 100 + j);
        end
        // Shadow config back to N=1, P=0 on every channel
        for (int k = 0; k < 4; k++) begin
            tick();
            push_exp(3'b111, k == 0, 1'b1, 1'b0, 8'd0, M_ALL, 8, 200 + k);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue left %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised multi-channel successor to the fixed three-output PLL wrapper.
- Runs on one PLL output clock and derives NUM_CH single-cycle clock-enable strobes from it, each with a runtime-programmable divide ratio and phase offset.
- Qualifies the PLL lock flag: synchronises and filters it, and tracks loss-of-lock events.
- Downstream logic (video timing, sampling, I/O) uses one clock plus these enables instead of extra PLL outputs.

Parameters:
- NUM_CH, 3, number of enable channels (1..8).
- DIV_W, 16, width of the per-channel divide-ratio and phase fields.
- LOCK_SYNC, 2, synchroniser depth for pll_locked (at least 2).
- LOCK_FILTER, 1024, consecutive synchronised-high cycles of pll_locked required before RUN.

Ports:
- clk  in  1  block clock (PLL output clock).
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pll_locked  in  1  raw PLL lock flag, asynchronous to clk.
- div_ratio  in  NUM_CH*DIV_W  per-channel divide N, channel i at bits [i*DIV_W +: DIV_W].
- phase_ofs  in  NUM_CH*DIV_W  per-channel phase offset P, same packing.
- cfg_update  in  1  one-cycle pulse requesting capture of div_ratio/phase_ofs.
- ch_enable  in  NUM_CH  per-channel output gate.
- ce_out  out  NUM_CH  one-cycle enable strobes.
- sync_pulse  out  1  one-cycle pulse marking the common alignment point of all channels.
- locked_stable  out  1  filtered lock indication; high only in RUN.
- cfg_ack  out  1  one-cycle pulse when a captured config takes effect.
- lock_loss_cnt  out  8  saturating count of RUN-to-lost transitions.

Behaviour:
- Reset values: ce_out=0, sync_pulse=0, locked_stable=0, cfg_ack=0, lock_loss_cnt=0, state=WAIT, shadow config N=1 and P=0 for all channels, pending flag=0.
- Lock path: pll_locked passes through LOCK_SYNC flops; lk_s is the synchronised value.
- States WAIT, FILTER, RUN, RELOAD:
  - WAIT: lk_s=1 -> FILTER, filter counter=1.
  - FILTER: counter increments while lk_s=1. lk_s=0 -> WAIT. Counter reaching LOCK_FILTER -> RUN.
  - RUN: lk_s=0 -> WAIT; locked_stable drops in the same cycle ce_out is forced 0; lock_loss_cnt +1, saturating at 255.
  - RUN: cfg_update=1 (and lk_s=1) -> RELOAD.
  - RELOAD: lasts one cycle, then -> RUN. lk_s=0 during RELOAD -> WAIT, counted as a loss.
- Configuration capture:
  - cfg_update in any state copies div_ratio/phase_ofs into the shadow registers on that cycle.
  - Outside RUN/RELOAD it sets pending=1.
  - On entry to RUN: pending cleared, cfg_ack pulses if pending was set.
  - In RELOAD: cfg_ack pulses.
  - cfg_update while already in RELOAD is captured and causes one further RELOAD cycle.
- Effective values:
  - N_eff = max(N,1): 0 is treated as 1.
  - P_eff = P if P < N_eff, else N_eff-1.
- Alignment point T0: first RUN cycle after FILTER or after RELOAD.
  - sync_pulse=1 at T0.
  - Every channel restarts its phase at T0.
- Channel i:
  - ce_out[i]=1 at cycles T0+P_eff, T0+P_eff+N_eff, T0+P_eff+2*N_eff, ...
  - For N_eff=1, ce_out[i] is high every RUN cycle.
  - ce_out[i] is gated by ch_enable[i] combinationally at the register input. Deasserting ch_enable suppresses strobes but does not disturb the count phase.
  - The countdown counter is DIV_W wide and wraps with no drift.
- ce_out and sync_pulse are 0 in WAIT, FILTER and RELOAD.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset assertion mid-operation returns everything to reset values immediately (asynchronous). Release is synchronised by the parent reset controller.

Decomposition:
- Shared package clk_enable_gen_pkg: state enum (WAIT, FILTER, RUN, RELOAD) and the lock_loss_cnt width constant (8).
- One natural sub-module, clk_enable_chan: a single channel's countdown counter, N_eff/P_eff clamp and strobe register, instantiated NUM_CH times in a generate loop.
- The top level holds the synchroniser, lock filter, FSM and shadow registers.

Test Plan (bench: LOCK_FILTER=16, NUM_CH=3, DIV_W=8):
1. Lock-up: raise pll_locked with N={4,1,3}, P={0,0,2} -> locked_stable high LOCK_SYNC+16 cycles later. At T0: sync_pulse=1, ce[0] and ce[1] high. ce[0] repeats every 4 cycles, ce[1] every cycle, ce[2] at T0+2, T0+5, ...
2. Filter glitch: drop pll_locked for 1 cycle after 10 high cycles -> FSM returns to WAIT, locked_stable stays 0, and the full 16-cycle count restarts.
3. Live reconfig: in RUN, pulse cfg_update with N[0]=5, P[0]=7 -> one RELOAD cycle with all ce=0 and cfg_ack=1. Then new T0 with sync_pulse; ce[0] at T0+4 (P clamped to 4), then every 5 cycles.
4. Loss of lock: drop pll_locked in RUN -> after synchroniser delay, locked_stable=0, ce_out=0 and lock_loss_cnt=1. Repeat 300 times -> saturates at 255.
5. Edge configs: N=0 behaves as N=1. ch_enable[2] cleared then set mid-run -> no strobes while low, and the phase is unchanged on re-enable.
6. Async reset mid-RUN: assert reset_n low between clock edges -> all outputs 0 immediately and the shadow config returns to N=1, P=0.
